addr_sequencer_v2: RTL and testbench

//  Next-generation FM-buffer address sequencer for layers that only move data (route/concat, nearest

---
 rtl/addr_sequencer_v2.sv | 175 +++++++++++++++++
 tb/tb_addr_sequencer_v2.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_sequencer_v2.sv
// FM-buffer address sequencer for route/concat and nearest-upsample layers.
// Emits one read address per element and the matching write address RD_LAT cycles later.
module addr_sequencer_v2 #(
    parameter int W_SIZE      = 9,
    parameter int W_CHANNEL   = 10,
    parameter int AW          = 17,
    parameter int MAX_UP_LOG2 = 2,
    parameter int RD_LAT      = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [W_SIZE-1:0]    q_width,
    input  logic [W_SIZE-1:0]    q_height,
    input  logic [W_CHANNEL-1:0] q_channel,
    input  logic [W_CHANNEL-1:0] q_channel_out,
    input  logic [W_CHANNEL-1:0] q_chn_offset,
    input  logic [AW-1:0]        q_rd_base,
    input  logic [AW-1:0]        q_wr_base,
    input  logic                 q_as_mode,
    input  logic [1:0]           q_up_log2,
    input  logic                 q_start,
    input  logic                 q_abort,
    input  logic                 as_rd_rdy,
    output logic                 as_rd_vld,
    output logic [AW-1:0]        as_rd_addr,
    output logic                 as_wr_vld,
    output logic [AW-1:0]        as_wr_addr,
    output logic                 busy,
    output logic                 done
);
    localparam int WD = W_SIZE + MAX_UP_LOG2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, EMPTY} state_t;
    state_t state, state_nxt;

    // Handshake: a read beat transfers when as_rd_vld & as_rd_rdy; writes are never stalled.
    logic [W_CHANNEL-1:0] c_last, chn;
    logic [WD-1:0]        wo_last, ho_last, mask, col, row;
    logic [AW-1:0]        c_step, co_step;
    logic [AW-1:0]        rd_row, rd_pix, wr_pix, wr_addr;
    logic [1:0]           s_start;
    logic                 zero_dim, start_ok, accept, last_beat, wr_done;

    logic [RD_LAT-1:0]         dl_vld, dl_last;
    logic [RD_LAT-1:0][AW-1:0] dl_addr;

    always_comb begin
        s_start = 2'd0;
        if (q_as_mode)
            s_start = (q_up_log2 > 2'(MAX_UP_LOG2)) ? 2'(MAX_UP_LOG2) : q_up_log2;
    end

    assign zero_dim  = (q_width == '0) || (q_height == '0) || (q_channel == '0);
    assign start_ok  = (state == IDLE) && q_start && !q_abort;
    assign accept    = (state == RUN) && as_rd_rdy && !q_abort;
    assign last_beat = (chn == c_last) && (col == wo_last) && (row == ho_last);
    assign wr_done   = dl_vld[RD_LAT-1] && dl_last[RD_LAT-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (q_abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (q_start) state_nxt = zero_dim ? EMPTY : RUN;
                RUN:     if (accept && last_beat) state_nxt = DRAIN;
                DRAIN:   if (wr_done) state_nxt = IDLE;
                EMPTY:   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        as_rd_vld = (state == RUN);
        busy      = (state != IDLE);
        done      = (state == EMPTY) || ((state == DRAIN) && wr_done);
    end

    // Incremental address walk: rd_pix is the current source pixel, rd_row the current source row.
    // Leaving the last pixel of a source row lands exactly on the next source row start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c_last     <= '0;
            wo_last    <= '0;
            ho_last    <= '0;
            mask       <= '0;
            c_step     <= '0;
            co_step    <= '0;
            chn        <= '0;
            col        <= '0;
            row        <= '0;
            rd_row     <= '0;
            rd_pix     <= '0;
            as_rd_addr <= '0;
            wr_pix     <= '0;
            wr_addr    <= '0;
        end else if (start_ok) begin
            c_last     <= q_channel - 1'b1;
            wo_last    <= (WD'(q_width) << s_start) - 1'b1;
            ho_last    <= (WD'(q_height) << s_start) - 1'b1;
            mask       <= (WD'(1) << s_start) - 1'b1;
            c_step     <= AW'(q_channel);
            co_step    <= AW'(q_channel_out);
            chn        <= '0;
            col        <= '0;
            row        <= '0;
            rd_row     <= q_rd_base;
            rd_pix     <= q_rd_base;
            as_rd_addr <= q_rd_base;
            wr_pix     <= q_wr_base + AW'(q_chn_offset);
            wr_addr    <= q_wr_base + AW'(q_chn_offset);
        end else if (accept) begin
            if (chn != c_last) begin
                chn        <= chn + 1'b1;
                as_rd_addr <= as_rd_addr + 1'b1;
                wr_addr    <= wr_addr + 1'b1;
            end else begin
                chn     <= '0;
                wr_pix  <= wr_pix + co_step;
                wr_addr <= wr_pix + co_step;
                if (col != wo_last) begin
                    col <= col + 1'b1;
                    if (((col + 1'b1) & mask) == '0) begin
                        rd_pix     <= rd_pix + c_step;
                        as_rd_addr <= rd_pix + c_step;
                    end else begin
                        as_rd_addr <= rd_pix;
                    end
                end else begin
                    col <= '0;
                    row <= row + 1'b1;
                    if (((row + 1'b1) & mask) == '0) begin
                        rd_row     <= rd_pix + c_step;
                        rd_pix     <= rd_pix + c_step;
                        as_rd_addr <= rd_pix + c_step;
                    end else begin
                        rd_pix     <= rd_row;
                        as_rd_addr <= rd_row;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dl_vld  <= '0;
            dl_last <= '0;
            dl_addr <= '0;
        end else if (q_abort) begin
            dl_vld  <= '0;
            dl_last <= '0;
            dl_addr <= '0;
        end else begin
            dl_vld[0]  <= accept;
            dl_last[0] <= accept && last_beat;
            dl_addr[0] <= wr_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                dl_vld[i]  <= dl_vld[i-1];
                dl_last[i] <= dl_last[i-1];
                dl_addr[i] <= dl_addr[i-1];
            end
        end
    end

    assign as_wr_vld  = dl_vld[RD_LAT-1];
    assign as_wr_addr = dl_addr[RD_LAT-1];

endmodule

// File: tb/tb_addr_sequencer_v2.sv
// Randomized scoreboard bench for addr_sequencer_v2: a loop-nest reference model fills
// expected queues at start; negedge monitors pop and compare reads, write timing and done.
module tb_addr_sequencer_v2;
    localparam int W_SIZE      = 9;
    localparam int W_CHANNEL   = 10;
    localparam int AW          = 17;
    localparam int MAX_UP_LOG2 = 2;
    localparam int RD_LAT      = 3;

    logic                 clk, rstn;
    logic [W_SIZE-1:0]    q_width, q_height;
    logic [W_CHANNEL-1:0] q_channel, q_channel_out, q_chn_offset;
    logic [AW-1:0]        q_rd_base, q_wr_base;
    logic                 q_as_mode, q_start, q_abort, as_rd_rdy;
    logic [1:0]           q_up_log2;
    logic                 as_rd_vld, as_wr_vld, busy, done;
    logic [AW-1:0]        as_rd_addr, as_wr_addr;

    addr_sequencer_v2 #(
        .W_SIZE(W_SIZE), .W_CHANNEL(W_CHANNEL), .AW(AW),
        .MAX_UP_LOG2(MAX_UP_LOG2), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rstn(rstn),
        .q_width(q_width), .q_height(q_height), .q_channel(q_channel),
        .q_channel_out(q_channel_out), .q_chn_offset(q_chn_offset),
        .q_rd_base(q_rd_base), .q_wr_base(q_wr_base),
        .q_as_mode(q_as_mode), .q_up_log2(q_up_log2),
        .q_start(q_start), .q_abort(q_abort), .as_rd_rdy(as_rd_rdy),
        .as_rd_vld(as_rd_vld), .as_rd_addr(as_rd_addr),
        .as_wr_vld(as_wr_vld), .as_wr_addr(as_wr_addr),
        .busy(busy), .done(done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [AW-1:0] rd_exp_q[$];
    logic [AW-1:0] wr_exp_q[$];
    logic [AW-1:0] wr_pend_q[$];
    int            wr_cyc_q[$];
    int            done_cyc_q[$];
    int            accepted;
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic flag(input string name);
        n_checks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // reference model: plain loop nest with multiplies, straight from the address formulas
    task automatic push_model(input int w, input int h, input int c, input int co, input int cf,
                              input int rb, input int wb, input bit mode, input int up);
        int s, wo, ho;
        s  = mode ? ((up > MAX_UP_LOG2) ? MAX_UP_LOG2 : up) : 0;
        wo = w * (1 << s);
        ho = h * (1 << s);
        for (int r = 0; r < ho; r++)
            for (int x = 0; x < wo; x++)
                for (int k = 0; k < c; k++) begin
                    rd_exp_q.push_back(AW'(rb + ((r / (1 << s)) * w + (x / (1 << s))) * c + k));
                    wr_exp_q.push_back(AW'(wb + (r * wo + x) * co + cf + k));
                end
    endtask

    // monitors
    always @(negedge clk) begin
        if (rstn) begin
            if (as_rd_vld) begin
                if (rd_exp_q.size() == 0) flag("rd_unexpected");
                else begin
                    check("rd_addr", 32'(as_rd_addr), 32'(rd_exp_q[0]));
                    if (as_rd_rdy && !q_abort) begin
                        void'(rd_exp_q.pop_front());
                        wr_pend_q.push_back(wr_exp_q.pop_front());
                        wr_cyc_q.push_back(cyc + RD_LAT);
                        accepted++;
                        if (rd_exp_q.size() == 0) done_cyc_q.push_back(cyc + RD_LAT);
                    end
                end
            end
            if (as_wr_vld) begin
                if (wr_pend_q.size() == 0) flag("wr_unexpected");
                else begin
                    check("wr_addr", 32'(as_wr_addr), 32'(wr_pend_q.pop_front()));
                    check("wr_cycle", 32'(cyc), 32'(wr_cyc_q.pop_front()));
                end
            end else if (wr_cyc_q.size() != 0 && wr_cyc_q[0] <= cyc) begin
                flag("wr_missing");
                void'(wr_cyc_q.pop_front());
                void'(wr_pend_q.pop_front());
            end
            if (done) begin
                if (done_cyc_q.size() == 0) flag("done_unexpected");
                else check("done_cycle", 32'(cyc), 32'(done_cyc_q.pop_front()));
            end else if (done_cyc_q.size() != 0 && done_cyc_q[0] <= cyc) begin
                flag("done_missing");
                void'(done_cyc_q.pop_front());
            end
        end
    end

    task automatic clear_sb();
        rd_exp_q.delete();
        wr_exp_q.delete();
        wr_pend_q.delete();
        wr_cyc_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic scramble_cfg();
        q_width       = W_SIZE'($urandom_range(0, 7));
        q_height      = W_SIZE'($urandom_range(0, 7));
        q_channel     = W_CHANNEL'($urandom_range(0, 7));
        q_channel_out = W_CHANNEL'($urandom);
        q_chn_offset  = W_CHANNEL'($urandom);
        q_rd_base     = AW'($urandom);
        q_wr_base     = AW'($urandom);
        q_as_mode     = 1'($urandom);
        q_up_log2     = 2'($urandom);
    endtask

    // driver tasks
    task automatic launch(input int w, input int h, input int c, input int co, input int cf,
                          input int rb, input int wb, input bit mode, input int up);
        @(posedge clk); #1;
        q_width = W_SIZE'(w); q_height = W_SIZE'(h); q_channel = W_CHANNEL'(c);
        q_channel_out = W_CHANNEL'(co); q_chn_offset = W_CHANNEL'(cf);
        q_rd_base = AW'(rb); q_wr_base = AW'(wb); q_as_mode = mode; q_up_log2 = 2'(up);
        q_start = 1'b1; as_rd_rdy = 1'b1; accepted = 0;
        push_model(w, h, c, co, cf, rb, wb, mode, up);
        if (w == 0 || h == 0 || c == 0) done_cyc_q.push_back(cyc + 1);
        @(posedge clk); #1;
        q_start = 1'b0;
        scramble_cfg();
        @(negedge clk);
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int rdy_mode, input bit restart_busy);
        int bp_left, budget;
        bit bp_used, finished;
        bp_left = 0; bp_used = 0; finished = 0;
        budget = 4 * rd_exp_q.size() + 60;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            q_start = restart_busy && (k == 2);
            if (rdy_mode == 2 && accepted == 4 && !bp_used) begin
                bp_used = 1; bp_left = 3;
            end
            if (rdy_mode == 1)      as_rd_rdy = ($urandom_range(0, 3) != 0);
            else if (bp_left > 0) begin as_rd_rdy = 1'b0; bp_left--; end
            else                    as_rd_rdy = 1'b1;
            if (rd_exp_q.size() == 0 && wr_pend_q.size() == 0 && done_cyc_q.size() == 0) begin
                finished = 1;
                break;
            end
        end
        q_start = 1'b0;
        if (!finished) begin
            flag("job_timeout");
            clear_sb();
        end
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        check("rd_vld_idle", 32'(as_rd_vld), 32'd0);
    endtask

    task automatic abort_run(input bit use_reset);
        launch(4, 2, 2, 2, 0, 7, 300, 1'b0, 0);
        for (int k = 0; k < 100 && accepted < 5; k++) begin
            @(posedge clk); #1;
        end
        check("abort_reached_beat5", 32'(accepted), 32'd5);
        if (use_reset) begin
            rstn = 1'b0;
            clear_sb();
            @(negedge clk);
            check("rst_rd_vld", 32'(as_rd_vld), 32'd0);
            check("rst_wr_vld", 32'(as_wr_vld), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_rd_addr", 32'(as_rd_addr), 32'd0);
            check("rst_wr_addr", 32'(as_wr_addr), 32'd0);
            @(posedge clk); #1;
            rstn = 1'b1;
        end else begin
            q_abort = 1'b1;
            @(posedge clk); #1;
            q_abort = 1'b0;
            clear_sb();
            @(negedge clk);
            check("abort_rd_vld", 32'(as_rd_vld), 32'd0);
            check("abort_wr_vld", 32'(as_wr_vld), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_done", 32'(done), 32'd0);
        end
        repeat (6) @(posedge clk);
        launch(2, 2, 1, 1, 0, 40, 500, 1'b1, 1);
        wait_done(1, 1'b0);
    endtask

    initial begin
        int w, h, c;
        rstn = 1'b0; q_start = 1'b0; q_abort = 1'b0; as_rd_rdy = 1'b1;
        scramble_cfg();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rd_vld", 32'(as_rd_vld), 32'd0);
        check("reset_wr_vld", 32'(as_wr_vld), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_rd_addr", 32'(as_rd_addr), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        launch(2, 2, 3, 8, 4, 100, 0, 1'b0, 2);   // route/concat example
        wait_done(0, 1'b0);
        launch(2, 1, 2, 2, 0, 0, 0, 1'b1, 1);     // upsample x2
        wait_done(0, 1'b0);
        launch(1, 1, 1, 1, 0, 55, 0, 1'b1, 3);    // clamped shift
        wait_done(0, 1'b0);
        launch(3, 2, 2, 2, 1, 10, 20, 1'b0, 0);   // backpressure + start while busy
        wait_done(2, 1'b1);
        launch(3, 2, 0, 4, 0, 10, 20, 1'b0, 0);   // C = 0
        wait_done(0, 1'b0);
        launch(0, 3, 2, 4, 0, 10, 20, 1'b1, 1);   // W = 0
        wait_done(0, 1'b0);
        abort_run(1'b0);
        abort_run(1'b1);

        for (int j = 0; j < 25; j++) begin
            w = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
            h = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            c = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            launch(w, h, c, c + $urandom_range(0, 4), $urandom_range(0, 7),
                   $urandom_range(0, (1 << AW) - 1), $urandom_range(0, (1 << AW) - 1),
                   1'($urandom), $urandom_range(0, 3));
            wait_done($urandom_range(0, 2), 1'b0);
        end

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
